// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU execute/writeback slice: opcodes,
// default widths and the execute FSM encoding.
package cpu_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 2;
  localparam int IMM_W      = 8;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_ADI = 4'h7;
  localparam logic [3:0] OP_LHI = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } state_t;

  // Single-cycle ALU ops occupy the contiguous low opcode range.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_LHI;
  endfunction
endpackage

// File: rtl/exec_wb_stage_if.sv
// Decode-issue handshake plus register-file read/write ports of the execute stage.
interface exec_wb_stage_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [ADDR_W-1:0] in_rs;
  logic [ADDR_W-1:0] in_rt;
  logic [ADDR_W-1:0] in_rd;
  logic [IMM_W-1:0]  in_imm;
  logic [ADDR_W-1:0] rf_addr1;
  logic [ADDR_W-1:0] rf_addr2;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_addr3;
  logic [DATA_W-1:0] rf_data3;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, rf_data1, rf_data2,
    input  in_ready, rf_addr1, rf_addr2, rf_write, rf_addr3, rf_data3
  );
  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, rf_data1, rf_data2,
    output in_ready, rf_addr1, rf_addr2, rf_write, rf_addr3, rf_data3
  );
endinterface

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier returning the low DATA_W bits of a*b
// after MUL_CYCLES iterations; done is asserted during the final iteration.
module seq_mul
  import cpu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MUL_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  logic [DATA_W-1:0] mcand, mplier, acc, acc_nxt;
  logic [CNT_W-1:0]  cnt;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign done    = busy && (cnt == CNT_W'(MUL_CYCLES - 1));
  // Product is taken combinationally so the last partial sum lands in WB
  // on the same edge that ends the multiply.
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/exec_wb_stage.sv
// Execute + writeback stage: operand forwarding, ALU, multicycle MUL FSM,
// single writeback register driving the RF write port, flags and retire counter.
module exec_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MUL_CYCLES = DATA_W
) (
  input  logic           clk,
  input  logic           reset,
  exec_wb_stage_if.slave bus,
  output logic           zero_flag,
  output logic           carry_flag,
  output logic [15:0]    retired_cnt
);
  state_t            state;
  logic              accept, mul_start, mul_busy, mul_done;
  logic [DATA_W-1:0] op_a, op_b, imm_sx, alu_res, mul_prod;
  logic [DATA_W:0]   sum;
  logic              alu_carry;
  logic              wb_valid, wb_load, wb_carry_nxt;
  logic [ADDR_W-1:0] wb_rd, wb_rd_nxt, mul_rd;
  logic [DATA_W-1:0] wb_data, wb_data_nxt;

  assign bus.in_ready = (state == S_IDLE) && !mul_busy;
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_start    = accept && (bus.in_op == OP_MUL);

  assign bus.rf_addr1 = bus.in_rs;
  assign bus.rf_addr2 = bus.in_rt;
  assign bus.rf_write = wb_valid;
  assign bus.rf_addr3 = wb_rd;
  assign bus.rf_data3 = wb_data;

  // The RF only commits WB at the end of this cycle, so a pending write wins.
  assign op_a   = (wb_valid && wb_rd == bus.in_rs) ? wb_data : bus.rf_data1;
  assign op_b   = (wb_valid && wb_rd == bus.in_rt) ? wb_data : bus.rf_data2;
  assign imm_sx = {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};

  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.in_op)
      OP_ADD: begin
        sum       = {1'b0, op_a} + {1'b0, op_b};
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      OP_SUB: begin
        sum       = {1'b0, op_a} + {1'b0, ~op_b} + 1'b1;
        alu_res   = sum[DATA_W-1:0];
        alu_carry = ~sum[DATA_W];
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_NOT: alu_res = ~op_a;
      OP_SHL: alu_res = op_a << op_b[3:0];
      OP_SHR: alu_res = op_a >> op_b[3:0];
      OP_ADI: begin
        sum       = {1'b0, op_a} + {1'b0, imm_sx};
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      OP_LHI: alu_res = DATA_W'({bus.in_imm, 8'h00});
      default: ;
    endcase
  end

  always_comb begin
    wb_load      = 1'b0;
    wb_rd_nxt    = bus.in_rd;
    wb_data_nxt  = alu_res;
    wb_carry_nxt = alu_carry;
    if (state == S_MUL_BUSY) begin
      wb_load      = mul_done;
      wb_rd_nxt    = mul_rd;
      wb_data_nxt  = mul_prod;
      wb_carry_nxt = 1'b0;
    end else if (accept && is_alu_op(bus.in_op)) begin
      wb_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      mul_rd      <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      zero_flag   <= 1'b0;
      carry_flag  <= 1'b0;
      retired_cnt <= '0;
    end else begin
      wb_valid <= wb_load;
      if (wb_load) begin
        wb_rd       <= wb_rd_nxt;
        wb_data     <= wb_data_nxt;
        zero_flag   <= (wb_data_nxt == '0);
        carry_flag  <= wb_carry_nxt;
        retired_cnt <= retired_cnt + 16'd1;
      end
      case (state)
        S_IDLE: if (mul_start) begin
          state  <= S_MUL_BUSY;
          mul_rd <= bus.in_rd;
        end
        S_MUL_BUSY: if (mul_done) state <= S_IDLE;
      endcase
    end
  end

  seq_mul #(
    .DATA_W    (DATA_W),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (op_a),
    .b      (op_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_prod)
  );
endmodule

// File: tb/tb_exec_wb_stage.sv
// Directed + random bench for exec_wb_stage with a register file in the loop and
// an in-order architectural model predicting every writeback and its cycle.
module tb_exec_wb_stage;
  import cpu_pkg::*;

  typedef struct {
    int          cyc;
    logic [1:0]  rd;
    logic [15:0] data;
    logic        z;
    logic        c;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        zero_flag, carry_flag;
  logic [15:0] retired_cnt;

  exec_wb_stage_if bus ();

  exec_wb_stage dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] rf  [4];
  logic [15:0] mrf [4];
  logic [15:0] mcnt;
  logic        mz, mc;
  exp_t        expq[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          ncmp = 0;
  int          nfail = 0;
  int          kmul;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) for (int i = 0; i < 4; i++) rf[i] <= '0;
    else if (bus.rf_write) rf[bus.rf_addr3] <= bus.rf_data3;
  end
  assign bus.rf_data1 = rf[bus.rf_addr1];
  assign bus.rf_data2 = rf[bus.rf_addr2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural result of one instruction in program order.
  task automatic model(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt,
                       input logic [1:0] rd, input logic [7:0] imm);
    int unsigned a, b, s, sx;
    logic [15:0] res;
    logic        c;
    bit          wr;
    int          lat;
    a = mrf[rs]; b = mrf[rt]; s = 0; c = 1'b0; wr = 1'b1; lat = 1; res = '0;
    sx = imm[7] ? (32'hFF00 + imm) : imm;
    case (op)
      OP_ADD: begin s = a + b;  res = 16'(s); c = (s > 32'hFFFF); end
      OP_SUB: begin res = 16'(a - b); c = (a < b); end
      OP_AND: res = 16'(a & b);
      OP_OR:  res = 16'(a | b);
      OP_NOT: res = 16'(~a);
      OP_SHL: res = 16'(a << (b % 16));
      OP_SHR: res = 16'(a >> (b % 16));
      OP_ADI: begin s = a + sx; res = 16'(s); c = (s > 32'hFFFF); end
      OP_LHI: res = 16'(imm * 256);
      OP_MUL: begin s = a * b; res = 16'(s); lat = 17; end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      mrf[rd] = res;
      mcnt    = mcnt + 16'd1;
      mz      = (res == 16'h0);
      mc      = c;
      expq.push_back('{cyc + lat, rd, res, mz, mc, mcnt});
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt,
                       input logic [1:0] rd, input logic [7:0] imm);
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin step(); n++; end
    check("ready_wait", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_rs = rs;
    bus.in_rt = rt; bus.in_rd = rd; bus.in_imm = imm;
    if (bus.in_ready) model(op, rs, rt, rd, imm);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mrf[i] = '0;
    mcnt = '0; mz = 1'b0; mc = 1'b0;
    expq.delete();
  endtask

  // Every RF write is matched against the oldest predicted writeback.
  always @(negedge clk) begin
    if (!reset && bus.rf_write) begin
      if (expq.size() == 0) check("spurious_wr", {31'b0, bus.rf_write}, 32'd0);
      else begin
        mon_e = expq.pop_front();
        check("wr_cycle", cyc, mon_e.cyc);
        check("wr_addr", {30'b0, bus.rf_addr3}, {30'b0, mon_e.rd});
        check("wr_data", {16'b0, bus.rf_data3}, {16'b0, mon_e.data});
        check("wr_zero", {31'b0, zero_flag}, {31'b0, mon_e.z});
        check("wr_carry", {31'b0, carry_flag}, {31'b0, mon_e.c});
        check("wr_cnt", {16'b0, retired_cnt}, {16'b0, mon_e.cnt});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_op = OP_NOP; bus.in_rs = '0;
    bus.in_rt = '0; bus.in_rd = '0; bus.in_imm = '0;
    model_reset();
    repeat (3) step();
    check("rst_wr", {31'b0, bus.rf_write}, 32'd0);
    check("rst_zero", {31'b0, zero_flag}, 32'd0);
    check("rst_carry", {31'b0, carry_flag}, 32'd0);
    check("rst_cnt", {16'b0, retired_cnt}, 32'd0);
    reset = 1'b0;
    check("rst_ready", {31'b0, bus.in_ready}, 32'd1);

    // ADD r1,r0,r0
    issue(OP_ADD, 2'd0, 2'd0, 2'd1, 8'h00);
    check("t1_wr", {31'b0, bus.rf_write}, 32'd1);
    check("t1_addr", {30'b0, bus.rf_addr3}, 32'd1);
    check("t1_data", {16'b0, bus.rf_data3}, 32'd0);
    check("t1_zero", {31'b0, zero_flag}, 32'd1);
    check("t1_cnt", {16'b0, retired_cnt}, 32'd1);

    // LHI then dependent ADI back-to-back
    issue(OP_LHI, 2'd0, 2'd0, 2'd1, 8'h12);
    check("t2_lhi", {16'b0, bus.rf_data3}, 32'h1200);
    issue(OP_ADI, 2'd1, 2'd0, 2'd2, 8'h34);
    check("t2_adi", {16'b0, bus.rf_data3}, 32'h1234);

    // carry and borrow, both operands forwarded
    issue(OP_NOT, 2'd0, 2'd0, 2'd1, 8'h00);
    issue(OP_ADD, 2'd1, 2'd1, 2'd2, 8'h00);
    check("t3_add", {16'b0, bus.rf_data3}, 32'hFFFE);
    check("t3_carry", {31'b0, carry_flag}, 32'd1);
    issue(OP_SUB, 2'd0, 2'd1, 2'd3, 8'h00);
    check("t3_sub", {16'b0, bus.rf_data3}, 32'h0001);
    check("t3_borrow", {31'b0, carry_flag}, 32'd1);

    // 3 * 5 with junk presented while busy, then dependent ADD
    issue(OP_LHI, 2'd0, 2'd0, 2'd1, 8'h00);
    issue(OP_ADI, 2'd1, 2'd0, 2'd1, 8'h03);
    issue(OP_LHI, 2'd0, 2'd0, 2'd2, 8'h00);
    issue(OP_ADI, 2'd2, 2'd0, 2'd2, 8'h05);
    kmul = cyc;
    issue(OP_MUL, 2'd1, 2'd2, 2'd3, 8'h00);
    bus.in_valid = 1'b1; bus.in_op = OP_ADD; bus.in_rd = 2'd0;
    for (int i = 0; i < 16; i++) begin
      check("t4_busy", {31'b0, bus.in_ready}, 32'd0);
      if (i == 15) bus.in_valid = 1'b0;
      step();
    end
    check("t4_ready", {31'b0, bus.in_ready}, 32'd1);
    check("t4_wr", {31'b0, bus.rf_write}, 32'd1);
    check("t4_lat", cyc - kmul, 32'd17);
    check("t4_prod", {16'b0, bus.rf_data3}, 32'h000F);
    issue(OP_ADD, 2'd3, 2'd3, 2'd0, 8'h00);
    check("t4_fwd", {16'b0, bus.rf_data3}, 32'h001E);

    // reset in MUL_BUSY cycle 8
    issue(OP_MUL, 2'd1, 2'd2, 2'd3, 8'h00);
    repeat (7) step();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
    check("t5_ready", {31'b0, bus.in_ready}, 32'd1);
    check("t5_cnt", {16'b0, retired_cnt}, 32'd0);
    check("t5_wr", {31'b0, bus.rf_write}, 32'd0);
    repeat (20) step();
    check("t5_cnt_late", {16'b0, retired_cnt}, 32'd0);

    // NOP and undefined opcode leave state alone
    issue(OP_NOT, 2'd0, 2'd0, 2'd1, 8'h00);
    issue(OP_ADI, 2'd1, 2'd0, 2'd2, 8'h01);
    issue(OP_NOP, 2'd1, 2'd2, 2'd3, 8'h00);
    check("t6_nop_wr", {31'b0, bus.rf_write}, 32'd0);
    check("t6_nop_zero", {31'b0, zero_flag}, {31'b0, mz});
    check("t6_nop_carry", {31'b0, carry_flag}, {31'b0, mc});
    issue(4'hE, 2'd1, 2'd2, 2'd3, 8'h00);
    check("t6_und_wr", {31'b0, bus.rf_write}, 32'd0);
    check("t6_und_cnt", {16'b0, retired_cnt}, {16'b0, mcnt});
    check("t6_und_carry", {31'b0, carry_flag}, 32'd1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    repeat (25) step();
    check("drain", expq.size(), 32'd0);
    for (int i = 0; i < 4; i++) check("rf_final", {16'b0, rf[i]}, {16'b0, mrf[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
